// File: rtl/exec_sequencer.sv
// PDP-8 execute sequencer: consumes decoded instructions, owns PC/AC/Link, drives a private data-memory port.
// Optional EXEC_STATS_EN adds a saturating retired-instruction counter. pdp_mem_opcode = {AND,TAD,ISZ,DCA,JMS,JMP,EA[11:0]}.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module exec_sequencer #(
    parameter logic [`ADDR_WIDTH-1:0] START_PC   = 12'o200,
    parameter int                     RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [`ADDR_WIDTH-1:0]   base_addr,
    input  logic [`ADDR_WIDTH+5:0]   pdp_mem_opcode,
    // op7 bits: 0 IAC, 1 RAL, 2 RAR, 3 CML, 4 CMA, 5 CLL, 6 CLA, 7 SMA, 8 SZA, 9 SNL, 10 SKP, 11 HLT
    input  logic [11:0]              pdp_op7_opcode,
    output logic                     stall,
    output logic [`ADDR_WIDTH-1:0]   PC_value,
    output logic                     exec_rd_req,
    output logic [`ADDR_WIDTH-1:0]   exec_rd_addr,
    input  logic [`DATA_WIDTH-1:0]   exec_rd_data,
    output logic                     exec_wr_req,
    output logic [`ADDR_WIDTH-1:0]   exec_wr_addr,
    output logic [`DATA_WIDTH-1:0]   exec_wr_data,
    output logic [`DATA_WIDTH-1:0]   ac_value,
    output logic                     link_value
`ifdef EXEC_STATS_EN
   ,output logic [31:0]              instr_retired
`endif
);
    typedef enum logic [2:0] {IDLE, EXEC, MEM_RD, MEM_WAIT, MEM_WR, HALTED} state_e;
    localparam logic [2:0] WAIT_INIT = 3'(RD_LATENCY - 1);

    state_e      state_q, state_d;
    logic        stall_q, stall_d, link_q, link_d;
    logic [11:0] pc_q, pc_d, ac_q, ac_d, ea_q, ea_d, p1_q, p1_d, op7_q, op7_d;
    logic [5:0]  mop_q, mop_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic        rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic [11:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic [11:0] t_ac;
    logic        t_link, skip;
    logic [12:0] sum;
    logic [5:0]  mop_i;
    logic [11:0] ea_i;

    assign mop_i = pdp_mem_opcode[17:12];
    assign ea_i  = pdp_mem_opcode[11:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;      stall_q <= 1'b1;     pc_q <= START_PC;
            ac_q <= '0;           link_q <= 1'b0;      ea_q <= '0;
            p1_q <= '0;           op7_q <= '0;         mop_q <= '0;
            wcnt_q <= '0;         rd_req_q <= 1'b0;    rd_addr_q <= '0;
            wr_req_q <= 1'b0;     wr_addr_q <= '0;     wr_data_q <= '0;
        end else begin
            state_q <= state_d;   stall_q <= stall_d;  pc_q <= pc_d;
            ac_q <= ac_d;         link_q <= link_d;    ea_q <= ea_d;
            p1_q <= p1_d;         op7_q <= op7_d;      mop_q <= mop_d;
            wcnt_q <= wcnt_d;     rd_req_q <= rd_req_d; rd_addr_q <= rd_addr_d;
            wr_req_q <= wr_req_d; wr_addr_q <= wr_addr_d; wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;  stall_d = stall_q;  pc_d = pc_q;
        ac_d = ac_q;        link_d = link_q;    ea_d = ea_q;
        p1_d = p1_q;        op7_d = op7_q;      mop_d = mop_q;
        wcnt_d = wcnt_q;
        rd_req_d = 1'b0;    rd_addr_d = '0;
        wr_req_d = 1'b0;    wr_addr_d = '0;     wr_data_d = '0;
        t_ac = ac_q;        t_link = link_q;    sum = '0;  skip = 1'b0;
        case (state_q)
            IDLE: begin
                stall_d = 1'b0;
                if (!stall_q && ((|mop_i) || (|pdp_op7_opcode))) begin
                    stall_d = 1'b1;
                    ea_d    = ea_i;
                    p1_d    = base_addr + 12'd1;
                    mop_d   = mop_i;
                    op7_d   = pdp_op7_opcode;
                    if (mop_i[5] || mop_i[4] || mop_i[3]) begin
                        state_d   = MEM_RD;
                        rd_req_d  = 1'b1;
                        rd_addr_d = ea_i;
                    end else begin
                        state_d = EXEC;
                        // Stores are launched at accept so the strobe lands in the EXEC cycle
                        if (mop_i[2]) begin
                            wr_req_d = 1'b1; wr_addr_d = ea_i; wr_data_d = ac_q;
                        end else if (mop_i[1]) begin
                            wr_req_d = 1'b1; wr_addr_d = ea_i; wr_data_d = base_addr + 12'd1;
                        end
                    end
                end
            end
            MEM_RD: begin
                state_d = MEM_WAIT;
                wcnt_d  = WAIT_INIT;
            end
            MEM_WAIT: begin
                if (wcnt_q != 3'd0) begin
                    wcnt_d = wcnt_q - 3'd1;
                end else if (mop_q[3] && !mop_q[5] && !mop_q[4]) begin
                    state_d   = MEM_WR;
                    wr_req_d  = 1'b1;
                    wr_addr_d = ea_q;
                    wr_data_d = exec_rd_data + 12'd1;
                end else begin
                    state_d = IDLE; stall_d = 1'b0; pc_d = p1_q;
                    if (mop_q[5]) begin
                        ac_d = ac_q & exec_rd_data;
                    end else begin
                        sum    = {1'b0, ac_q} + {1'b0, exec_rd_data};
                        ac_d   = sum[11:0];
                        link_d = link_q ^ sum[12];
                    end
                end
            end
            MEM_WR: begin
                state_d = IDLE; stall_d = 1'b0;
                pc_d    = (wr_data_q == 12'd0) ? p1_q + 12'd1 : p1_q;
            end
            EXEC: begin
                state_d = IDLE; stall_d = 1'b0; pc_d = p1_q;
                if (mop_q[2]) begin
                    ac_d = '0;
                end else if (mop_q[1]) begin
                    pc_d = ea_q + 12'd1;
                end else if (mop_q[0]) begin
                    pc_d = ea_q;
                end else if (|op7_q[11:7]) begin
                    // Group 2: skip test sees AC before the optional clear
                    skip = (op7_q[7] & ac_q[11]) | (op7_q[8] & (ac_q == 12'd0)) |
                           (op7_q[9] & link_q) | op7_q[10];
                    if (op7_q[6]) ac_d = '0;
                    pc_d = skip ? p1_q + 12'd1 : p1_q;
                    if (op7_q[11]) begin
                        state_d = HALTED; stall_d = 1'b1; pc_d = p1_q;
                    end
                end else begin
                    if (op7_q[6]) t_ac = '0;
                    if (op7_q[5]) t_link = 1'b0;
                    if (op7_q[4]) t_ac = ~t_ac;
                    if (op7_q[3]) t_link = ~t_link;
                    if (op7_q[0]) begin
                        sum    = {1'b0, t_ac} + 13'd1;
                        t_ac   = sum[11:0];
                        t_link = t_link ^ sum[12];
                    end
                    if (op7_q[1])      {t_link, t_ac} = {t_ac, t_link};
                    else if (op7_q[2]) {t_ac, t_link} = {t_link, t_ac};
                    ac_d   = t_ac;
                    link_d = t_link;
                end
            end
            HALTED:  stall_d = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign stall        = stall_q;
    assign PC_value     = pc_q;
    assign ac_value     = ac_q;
    assign link_value   = link_q;
    assign exec_rd_req  = rd_req_q;
    assign exec_rd_addr = rd_addr_q;
    assign exec_wr_req  = wr_req_q;
    assign exec_wr_addr = wr_addr_q;
    assign exec_wr_data = wr_data_q;

`ifdef EXEC_STATS_EN
    logic        retire;
    logic [31:0] cnt_q;
    assign retire = (state_q != IDLE) && (state_q != HALTED) &&
                    ((state_d == IDLE) || (state_d == HALTED));
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          cnt_q <= '0;
        else if (retire && cnt_q != '1)     cnt_q <= cnt_q + 32'd1;
    end
    assign instr_retired = cnt_q;
`endif
endmodule
